mem_resp: RTL and testbench

- Memory-side responder for the 8-bit CPU address bus.
- Accepts the address driven by the CPU's address-source mux (PC or operand address), plus request, write-enable and write data.
- Performs the read or write on an internal synchronous RAM.
- Returns read data with a one-cycle ready pulse after a programmable number of wait states. Gives the datapath a realistic, stallable memory.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_resp_if.sv | 29 ++
 rtl/mem_array.sv | 39 +++
 rtl/mem_resp.sv | 151 +++++++++++++++
 tb/tb_mem_resp.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the mem_resp memory responder.
// FSM encoding, counter width, index-width helper and the
// out-of-range read pattern.
package mem_pkg;

   // Responder FSM states.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Wait-state counter width (WAIT is limited to 0..15).
   localparam int CNT_W = 4;

   // Read data returned for an out-of-range read; truncated to DATA_W at use.
   localparam logic [63:0] ERR_RDATA = '1;

   // RAM index width for a given depth: clog2(DEPTH), at least 1 bit.
   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mem_resp_if.sv
// mem_resp_if: CPU-side memory bus between the address mux and mem_resp.
// Handshake: the master raises req with A/we/wdata valid; the responder
// takes them on any rising edge where it can accept (busy low, or the
// cycle of a completing access). Inputs are ignored at other times. The
// access completes with a single-cycle ready pulse; rdata is valid from
// that cycle and holds until the next read completes.
interface mem_resp_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] A;
   logic              req;
   logic              we;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              busy;
   logic              err;

   modport master (
      output A, req, we, wdata,
      input  rdata, ready, busy, err
   );

   modport slave (
      input  A, req, we, wdata,
      output rdata, ready, busy, err
   );
endinterface

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM, DEPTH x DATA_W.
// Write on i_en & i_we; registered read on i_en & ~i_we. Only the read
// register is reset; the storage itself keeps its contents.
module mem_array #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_en,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Storage write port; not reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (i_en && i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   // Read register: updates only on a read, holds across writes and idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_en && !i_we) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_resp.sv
// mem_resp: memory-side responder for the CPU address bus.
// Latches an access on accept, counts WAIT wait states, issues the RAM
// access and returns a one-cycle ready pulse WAIT+1 edges after accept.
// Optional feature macro: MEM_ERR_EN (address range check with err pulse).
module mem_resp
   import mem_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256,
   parameter int WAIT   = 1
) (
   input  logic         clk,
   input  logic         rst,
   mem_resp_if.slave    bus,
   output state_t       o_dbg_state
);

   localparam int IDX_W = idx_w(DEPTH);

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_we;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_ready;
   logic                w_accept;
   logic                w_issue;
   logic                w_ram_en;
   logic [DATA_W-1:0]   w_ram_q;

   // New requests are taken when idle or while the previous access is issued.
   assign w_accept = bus.req && ((r_state == S_IDLE) || (r_state == S_RESP));
   // S_RESP is the cycle in which the latched access is applied to the RAM;
   // the RAM result and the ready pulse appear in the following cycle.
   assign w_issue  = (r_state == S_RESP);

   // Next-state and wait-counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE, S_RESP: begin
            if (w_accept) begin
               if (WAIT == 0) begin
                  w_state_nxt = S_RESP;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = CNT_W'(WAIT - 1);
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_RESP;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and counter registers; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Access latches: captured on accept so later bus changes are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_addr  <= bus.A;
         r_we    <= bus.we;
         r_wdata <= bus.wdata;
      end
   end

   // Completion pulse: one cycle after the access is issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ready <= 1'b0;
      end else begin
         r_ready <= w_issue;
      end
   end

`ifdef MEM_ERR_EN
   logic w_oob;
   logic r_err;
   logic r_err_rd;

   assign w_oob    = ({1'b0, r_addr} >= (ADDR_W + 1)'(DEPTH));
   // Out-of-range accesses never touch the RAM; reset gating keeps a
   // write from landing on the reset edge.
   assign w_ram_en = w_issue && !w_oob && !rst;

   // Error pulse alongside ready; sticky flag selects the all-ones read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err    <= 1'b0;
         r_err_rd <= 1'b0;
      end else begin
         r_err <= w_issue && w_oob;
         if (w_issue && !r_we) begin
            r_err_rd <= w_oob;
         end
      end
   end

   assign bus.err   = r_err;
   assign bus.rdata = r_err_rd ? DATA_W'(ERR_RDATA) : w_ram_q;
`else
   // Without the range check the index simply wraps modulo DEPTH.
   assign w_ram_en  = w_issue && !rst;
   assign bus.err   = 1'b0;
   assign bus.rdata = w_ram_q;
`endif

   mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_ram_en),
      .i_we    (r_we),
      .i_addr  (r_addr[IDX_W-1:0]),
      .i_wdata (r_wdata),
      .o_rdata (w_ram_q)
   );

   assign bus.ready   = r_ready;
   assign bus.busy    = (r_state != S_IDLE);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: directed bench for mem_resp with four instances
// (WAIT=1, WAIT=0, WAIT=3, DEPTH=128/WAIT=1). Honours MEM_ERR_EN.
module tb_mem_resp;
   import mem_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_resp_if #(.DATA_W(8), .ADDR_W(8)) bus_w1 ();
   mem_resp_if #(.DATA_W(8), .ADDR_W(8)) bus_w0 ();
   mem_resp_if #(.DATA_W(8), .ADDR_W(8)) bus_w3 ();
   mem_resp_if #(.DATA_W(8), .ADDR_W(8)) bus_d  ();

   state_t st_w1, st_w0, st_w3, st_d;

   mem_resp #(.WAIT(1)) u_w1 (.clk(clk), .rst(rst), .bus(bus_w1), .o_dbg_state(st_w1));
   mem_resp #(.WAIT(0)) u_w0 (.clk(clk), .rst(rst), .bus(bus_w0), .o_dbg_state(st_w0));
   mem_resp #(.WAIT(3)) u_w3 (.clk(clk), .rst(rst), .bus(bus_w3), .o_dbg_state(st_w3));
   mem_resp #(.DEPTH(128), .WAIT(1)) u_d (.clk(clk), .rst(rst), .bus(bus_d), .o_dbg_state(st_d));

`ifdef MEM_ERR_EN
   localparam logic       EXP_ERR  = 1'b1;
   localparam logic [7:0] EXP_RD80 = 8'hFF;
   localparam logic [7:0] EXP_RD00 = 8'hC3;
`else
   localparam logic       EXP_ERR  = 1'b0;
   localparam logic [7:0] EXP_RD80 = 8'h5A;
   localparam logic [7:0] EXP_RD00 = 8'h5A;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   logic [7:0] exp_q[$];

   // Single comparison point: counts and reports.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // WAIT=3 access: returns in the ready cycle (4 edges after accept).
   task automatic acc_w3(input logic we, input logic [7:0] a, input logic [7:0] d);
      bus_w3.req = 1'b1; bus_w3.we = we; bus_w3.A = a; bus_w3.wdata = d;
      step();
      bus_w3.req = 1'b0;
      repeat (4) step();
   endtask

   // DEPTH=128 / WAIT=1 access: returns in the ready cycle (2 edges after accept).
   task automatic acc_d(input logic we, input logic [7:0] a, input logic [7:0] d);
      bus_d.req = 1'b1; bus_d.we = we; bus_d.A = a; bus_d.wdata = d;
      step();
      bus_d.req = 1'b0;
      repeat (2) step();
   endtask

   initial begin
      bus_w1.req = 0; bus_w1.we = 0; bus_w1.A = 0; bus_w1.wdata = 0;
      bus_w0.req = 0; bus_w0.we = 0; bus_w0.A = 0; bus_w0.wdata = 0;
      bus_w3.req = 0; bus_w3.we = 0; bus_w3.A = 0; bus_w3.wdata = 0;
      bus_d.req  = 0; bus_d.we  = 0; bus_d.A  = 0; bus_d.wdata  = 0;

      // Reset then idle.
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      repeat (5) step();
      chk("rst_rdata", bus_w1.rdata, 8'h00);
      chk("rst_ready", bus_w1.ready, 1'b0);
      chk("rst_busy",  bus_w1.busy,  1'b0);
      chk("rst_err",   bus_d.err,    1'b0);

      // WAIT=1: write 0x10 <- 0xA5, then read it back.
      bus_w1.req = 1; bus_w1.we = 1; bus_w1.A = 8'h10; bus_w1.wdata = 8'hA5;
      step();
      bus_w1.req = 0; bus_w1.A = 8'h00; bus_w1.wdata = 8'h00;
      chk("w1_wr_busy_e0",  bus_w1.busy,  1'b1);
      chk("w1_wr_ready_e0", bus_w1.ready, 1'b0);
      step();
      chk("w1_wr_ready_e1", bus_w1.ready, 1'b0);
      step();
      chk("w1_wr_ready_e2", bus_w1.ready, 1'b1);
      chk("w1_wr_rdata",    bus_w1.rdata, 8'h00);
      chk("w1_wr_busy_e2",  bus_w1.busy,  1'b0);
      bus_w1.req = 1; bus_w1.we = 0; bus_w1.A = 8'h10;
      step();
      bus_w1.req = 0;
      step();
      chk("w1_rd_ready_e1", bus_w1.ready, 1'b0);
      step();
      chk("w1_rd_ready_e2", bus_w1.ready, 1'b1);
      chk("w1_rd_rdata",    bus_w1.rdata, 8'hA5);
      step();
      chk("w1_rd_ready_off", bus_w1.ready, 1'b0);
      chk("w1_rd_hold",      bus_w1.rdata, 8'hA5);

      // WAIT=0: back-to-back preload writes, then back-to-back reads.
      bus_w0.req = 1; bus_w0.we = 1;
      for (int i = 1; i <= 3; i++) begin
         bus_w0.A = 8'(i); bus_w0.wdata = 8'(i * 17);
         step();
      end
      bus_w0.req = 0;
      step();
      chk("w0_wr_ready_last", bus_w0.ready, 1'b1);
      chk("w0_wr_rdata_hold", bus_w0.rdata, 8'h00);
      step();
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
      bus_w0.req = 1; bus_w0.we = 0; bus_w0.A = 8'h01;
      step();
      for (int i = 2; i <= 4; i++) begin
         if (i <= 3) bus_w0.A = 8'(i);
         else        bus_w0.req = 0;
         step();
         chk("w0_rd_ready", bus_w0.ready, 1'b1);
         chk("w0_rd_rdata", bus_w0.rdata, exp_q.pop_front());
      end
      step();
      chk("w0_ready_off", bus_w0.ready, 1'b0);
      chk("w0_busy_off",  bus_w0.busy,  1'b0);

      // WAIT=3: bus changes during WAIT are ignored.
      acc_w3(1'b1, 8'h40, 8'h77);
      chk("w3_wr40_ready", bus_w3.ready, 1'b1);
      step();
      acc_w3(1'b1, 8'h41, 8'h99);
      step();
      bus_w3.req = 1; bus_w3.we = 0; bus_w3.A = 8'h40;
      step();
      chk("w3_busy_e0", bus_w3.busy, 1'b1);
      bus_w3.req = 1; bus_w3.we = 1; bus_w3.A = 8'h41; bus_w3.wdata = 8'h00;
      step();
      chk("w3_ready_e1", bus_w3.ready, 1'b0);
      bus_w3.req = 0; bus_w3.A = 8'h42;
      step();
      chk("w3_ready_e2", bus_w3.ready, 1'b0);
      step();
      chk("w3_ready_e3", bus_w3.ready, 1'b0);
      step();
      chk("w3_ready_e4", bus_w3.ready, 1'b1);
      chk("w3_rdata_e4", bus_w3.rdata, 8'h77);
      step();
      chk("w3_ready_off", bus_w3.ready, 1'b0);
      acc_w3(1'b0, 8'h41, 8'h00);
      chk("w3_rd41_kept", bus_w3.rdata, 8'h99);
      step();

      // WAIT=3: reset in the middle of a write abandons it.
      acc_w3(1'b1, 8'h20, 8'h3C);
      step();
      bus_w3.req = 1; bus_w3.we = 1; bus_w3.A = 8'h20; bus_w3.wdata = 8'h5A;
      step();
      bus_w3.req = 0;
      step();
      rst = 1'b1;
      step();
      chk("w3_rst_ready", bus_w3.ready, 1'b0);
      chk("w3_rst_busy",  bus_w3.busy,  1'b0);
      step();
      chk("w3_rst_rdata", bus_w3.rdata, 8'h00);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("w3_post_rst_ready", bus_w3.ready, 1'b0);
      end
      acc_w3(1'b0, 8'h20, 8'h00);
      chk("w3_rd20_ready", bus_w3.ready, 1'b1);
      chk("w3_rd20_old",   bus_w3.rdata, 8'h3C);
      step();

      // DEPTH=128: address 0x80 is out of range or wraps to 0x00.
      acc_d(1'b1, 8'h00, 8'hC3);
      chk("d_wr00_ready", bus_d.ready, 1'b1);
      chk("d_wr00_err",   bus_d.err,   1'b0);
      step();
      acc_d(1'b1, 8'h80, 8'h5A);
      chk("d_wr80_ready", bus_d.ready, 1'b1);
      chk("d_wr80_err",   bus_d.err,   EXP_ERR);
      step();
      chk("d_err_pulse",  bus_d.err,   1'b0);
      acc_d(1'b0, 8'h80, 8'h00);
      chk("d_rd80_ready", bus_d.ready, 1'b1);
      chk("d_rd80_err",   bus_d.err,   EXP_ERR);
      chk("d_rd80_rdata", bus_d.rdata, EXP_RD80);
      step();
      acc_d(1'b0, 8'h00, 8'h00);
      chk("d_rd00_err",   bus_d.err,   1'b0);
      chk("d_rd00_rdata", bus_d.rdata, EXP_RD00);
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
